// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential shift-add unsigned multiplier controller that
// borrows an external combinational adder instead of owning one.
//   clk, rst          - clock; synchronous active-high reset
//   start             - begin a multiply (accepted only in IDLE)
//   multiplicand      - operand M, captured when start is accepted
//   multiplier        - operand Q, captured when start is accepted
//   add_a, add_b      - operands presented to the shared adder
//   add_sum           - adder result (a+b mod 2^WIDTH), same cycle
//   hi, lo            - upper/lower halves of the product
//   busy, done        - high in RUN / high for the single DONE cycle
module mul_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic             w_carry;
  logic             w_last;

  // The adder has no carry-out; a wrapped unsigned sum is smaller than add_a.
  assign add_a   = r_hi;
  assign add_b   = r_lo[0] ? r_m : '0;
  assign w_carry = (add_sum < r_hi);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign hi = r_hi;
  assign lo = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= multiplicand;
            r_hi  <= '0;
            r_lo  <= multiplier;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          // Add-then-shift right: carry enters the MSB, consumed Q bit falls out.
          {r_hi, r_lo} <= {w_carry, add_sum, r_lo[WIDTH-1:1]};
          r_cnt        <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_model = '0;

  // External shared adder.
  assign add_sum = add_a + add_b;

  mul_seq_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_adder(input string tag);
    check_eq({tag, "_adda"}, {32'd0, add_a}, {32'd0, hi});
    check_eq({tag, "_addb"}, {32'd0, add_b}, {32'd0, (lo[0] ? m_model : 32'd0)});
  endtask

  // Runs one multiply from IDLE and observes 40 cycles after acceptance.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit disturb);
    int busy_cnt = 0;
    int done_at  = -1;
    int done_cnt = 0;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    m_model = m;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check_adder(tag);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          check_eq({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
          check_eq({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        end
      end
      if (disturb && k == 5) begin
        multiplicand = ~m;
        multiplier   = 32'h0000_0005;
        start        = 1'b1;
      end
      if (disturb && k == 6) start = 1'b0;
    end
    check_eq({tag, "_busycyc"}, 64'(busy_cnt), 64'd32);
    check_eq({tag, "_doneat"},  64'(done_at),  64'd33);
    check_eq({tag, "_donecnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_idle"},    {62'd0, busy, done}, 64'd0);
    check_eq({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int k_done[$];
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_prod", {hi, lo}, 64'd0);

    run_op("basic",   32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F, 1'b0);
    run_op("carry",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("zero",    32'h1234_5678,  32'd0,          32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op("ident",   32'h1234_5678,  32'd1,          32'h0000_0000, 32'h1234_5678, 1'b0);
    run_op("hold",    32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000, 1'b1);
    run_op("mix",     32'h8000_0001,  32'h0000_0003,  32'h0000_0001, 32'h8000_0003, 1'b0);

    // Reset in the middle of a run.
    @(negedge clk);
    multiplicand = 32'h1234_5678;
    multiplier   = 32'd3;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("midrst_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_model = '0;
    @(negedge clk);
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_prod", {hi, lo}, 64'd0);
    begin
      int stray = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (done || busy) stray++;
      end
      check_eq("midrst_nodone", 64'(stray), 64'd0);
    end
    run_op("after_rst", 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    multiplicand = 32'd2;
    multiplier   = 32'd3;
    start        = 1'b1;
    @(posedge clk);
    m_model = 32'd2;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      check_adder("b2b");
      if (done) begin
        k_done.push_back(k);
        check_eq("b2b_lo", {32'd0, lo}, 64'd6);
        check_eq("b2b_hi", {32'd0, hi}, 64'd0);
      end
    end
    start = 1'b0;
    check_eq("b2b_count", 64'(k_done.size()), 64'd3);
    if (k_done.size() == 3) begin
      check_eq("b2b_first", 64'(k_done[0]), 64'd33);
      check_eq("b2b_gap1",  64'(k_done[1] - k_done[0]), 64'd34);
      check_eq("b2b_gap2",  64'(k_done[2] - k_done[1]), 64'd34);
    end
    repeat (40) @(negedge clk);
    check_eq("b2b_end_idle", {62'd0, busy, done}, 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
